interrupt_controller: RTL and testbench

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/interrupt_controller.sv | 202 ++++++++++++++++++++
 tb/tb_interrupt_controller.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// interrupt_controller: single-level interrupt sequencer for a pipelined core.
// Flow: IDLE -> DRAIN -> VECTOR -> ISR -> RETURN -> IDLE.
// Optional macro IRQ_EDGE_EN selects edge-triggered pending latches.
// The default build uses level-sensitive pending latches.
// All outputs are registered and line up with the state they belong to.
module interrupt_controller #(
  parameter int unsigned N_IRQ        = 4,
  parameter logic [15:0] VECTOR_BASE  = 16'h0010,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic             IEN_d,
  input  logic             IOF_d,
  input  logic             RTI_d,
  input  logic [15:0]      pc_f,
  input  logic [3:0]       flags_i,
  input  logic             pipe_ready,
  output logic             stall,
  output logic             flush,
  output logic             pc_redirect,
  output logic [15:0]      pc_target,
  output logic             flags_restore,
  output logic [3:0]       flags_o,
  output logic             int_enabled,
  output logic             in_isr,
  output logic [N_IRQ-1:0] irq_ack,
  output logic [N_IRQ-1:0] irq_pending
);

  localparam int unsigned IDW        = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
  localparam logic [2:0]  DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRAIN  = 3'd1,
    S_VECTOR = 3'd2,
    S_ISR    = 3'd3,
    S_RETURN = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [15:0]      epc_q, epc_d;
  logic [3:0]       eflags_q, eflags_d;
  logic [IDW-1:0]   id_q, id_d;
  logic             int_en_q, int_en_d;
  logic [N_IRQ-1:0] pend_q, pend_d;
  logic [IDW-1:0]   pick;

  logic             stall_q, stall_d;
  logic             flush_q, flush_d;
  logic             redir_q, redir_d;
  logic [15:0]      tgt_q, tgt_d;
  logic             frest_q, frest_d;
  logic [3:0]       flags_o_q, flags_o_d;
  logic             in_isr_q, in_isr_d;
  logic [N_IRQ-1:0] ack_q, ack_d;

  // Lowest-index pending line wins.
  always_comb begin
    pick = '0;
    for (int i = N_IRQ - 1; i >= 0; i--)
      if (pend_q[i]) pick = IDW'(i);
  end

`ifdef IRQ_EDGE_EN
  logic [N_IRQ-1:0] irq_prev_q, irq_prev_d;

  // Edge mode: a fresh rising edge beats an ack of the same line.
  always_comb begin
    irq_prev_d = irq_i;
    pend_d     = (pend_q & ~ack_q) | (irq_i & ~irq_prev_q);
  end

  // Previous request level for edge detection.
  always_ff @(posedge clk) begin
    if (rst) irq_prev_q <= '0;
    else     irq_prev_q <= irq_prev_d;
  end
`else
  // Level mode: pending simply mirrors the registered request lines.
  always_comb begin
    pend_d = irq_i;
  end
`endif

  // Sequencer next state and captured context.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    epc_d    = epc_q;
    eflags_d = eflags_q;
    id_d     = id_q;
    int_en_d = int_en_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (IOF_d)      int_en_d = 1'b0;
        else if (IEN_d) int_en_d = 1'b1;
        if (int_en_q && !IOF_d && (|pend_q)) begin
          epc_d    = pc_f;
          eflags_d = flags_i;
          id_d     = pick;
          state_d  = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((cnt_q >= DRAIN_LAST) && pipe_ready) begin
          // Enable drops together with the vector redirect.
          state_d  = S_VECTOR;
          cnt_d    = '0;
          int_en_d = 1'b0;
        end else if (cnt_q != 3'd7) begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_VECTOR: state_d = S_ISR;
      S_ISR: begin
        if (RTI_d) begin
          // Enable comes back together with the return redirect.
          state_d  = S_RETURN;
          int_en_d = 1'b1;
        end
      end
      S_RETURN: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the upcoming state so they register in step with it.
  always_comb begin
    stall_d   = (state_d == S_DRAIN) || (state_d == S_VECTOR) || (state_d == S_RETURN);
    flush_d   = (state_d == S_DRAIN) && (state_q != S_DRAIN);
    redir_d   = 1'b0;
    tgt_d     = '0;
    frest_d   = 1'b0;
    flags_o_d = '0;
    in_isr_d  = (state_d == S_ISR);
    ack_d     = '0;
    if (state_d == S_VECTOR) begin
      redir_d = 1'b1;
      tgt_d   = VECTOR_BASE + {{(14 - IDW){1'b0}}, id_q, 2'b00};
      ack_d   = N_IRQ'(1) << id_q;
    end else if (state_d == S_RETURN) begin
      redir_d   = 1'b1;
      tgt_d     = epc_q;
      frest_d   = 1'b1;
      flags_o_d = eflags_q;
    end
  end

  // State, context and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      epc_q     <= '0;
      eflags_q  <= '0;
      id_q      <= '0;
      int_en_q  <= 1'b0;
      pend_q    <= '0;
      stall_q   <= 1'b0;
      flush_q   <= 1'b0;
      redir_q   <= 1'b0;
      tgt_q     <= '0;
      frest_q   <= 1'b0;
      flags_o_q <= '0;
      in_isr_q  <= 1'b0;
      ack_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      epc_q     <= epc_d;
      eflags_q  <= eflags_d;
      id_q      <= id_d;
      int_en_q  <= int_en_d;
      pend_q    <= pend_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
      redir_q   <= redir_d;
      tgt_q     <= tgt_d;
      frest_q   <= frest_d;
      flags_o_q <= flags_o_d;
      in_isr_q  <= in_isr_d;
      ack_q     <= ack_d;
    end
  end

  assign stall         = stall_q;
  assign flush         = flush_q;
  assign pc_redirect   = redir_q;
  assign pc_target     = tgt_q;
  assign flags_restore = frest_q;
  assign flags_o       = flags_o_q;
  assign int_enabled   = int_en_q;
  assign in_isr        = in_isr_q;
  assign irq_ack       = ack_q;
  assign irq_pending   = pend_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller (default parameters).
// Sequences keep request lines held/dropped so they hold in either pending mode.
module tb_interrupt_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  irq_i = '0;
  logic        IEN_d = 1'b0, IOF_d = 1'b0, RTI_d = 1'b0;
  logic [15:0] pc_f = '0;
  logic [3:0]  flags_i = '0;
  logic        pipe_ready = 1'b0;
  logic        stall, flush, pc_redirect, flags_restore, int_enabled, in_isr;
  logic [15:0] pc_target;
  logic [3:0]  flags_o, irq_ack, irq_pending;

  int n_vec = 0;
  int n_err = 0;

  interrupt_controller dut (
    .clk(clk), .rst(rst), .irq_i(irq_i), .IEN_d(IEN_d), .IOF_d(IOF_d), .RTI_d(RTI_d),
    .pc_f(pc_f), .flags_i(flags_i), .pipe_ready(pipe_ready),
    .stall(stall), .flush(flush), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .flags_restore(flags_restore), .flags_o(flags_o), .int_enabled(int_enabled),
    .in_isr(in_isr), .irq_ack(irq_ack), .irq_pending(irq_pending)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    IEN_d = 0; IOF_d = 0; RTI_d = 0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    // ---- reset state and enable-off behaviour with all lines high
    irq_i = 4'hF; pipe_ready = 1'b1;
    do_reset();
    chk("rst_stall", stall, 0);
    chk("rst_redir", pc_redirect, 0);
    chk("rst_target", pc_target, 16'h0);
    chk("rst_int_en", int_enabled, 0);
    chk("rst_pending", irq_pending, 4'h0);
    chk("rst_ack", irq_ack, 4'h0);
    chk("rst_isr", in_isr, 0);
    RTI_d = 1'b1;                       // RTI outside ISR is a no-op
    step();
    chk("dis_pending", irq_pending, 4'hF);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("dis_stall", stall, 0);
      chk("dis_redir", pc_redirect, 0);
    end
    RTI_d = 1'b0;

    // ---- basic entry/return on line 2
    irq_i = 4'h0;
    do_reset();
    IEN_d = 1'b1; step(); IEN_d = 1'b0;
    chk("ien_set", int_enabled, 1);
    irq_i = 4'b0100; pc_f = 16'h0123; flags_i = 4'b1010;
    step();
    chk("b_pending", irq_pending, 4'b0100);
    chk("b_nostall", stall, 0);
    step();                             // first DRAIN cycle
    chk("b_flush1", flush, 1);
    chk("b_stall1", stall, 1);
    chk("b_redir1", pc_redirect, 0);
    pc_f = 16'hBEEF; flags_i = 4'b0001; // must not disturb captured context
    step();
    chk("b_flush2", flush, 0);
    chk("b_stall2", stall, 1);
    chk("b_redir2", pc_redirect, 0);
    step();                             // VECTOR
    chk("b_vredir", pc_redirect, 1);
    chk("b_vtarget", pc_target, 16'h0018);
    chk("b_vack", irq_ack, 4'b0100);
    chk("b_vint_en", int_enabled, 0);
    step();                             // ISR
    chk("b_isr", in_isr, 1);
    chk("b_isr_redir", pc_redirect, 0);
    chk("b_isr_ack", irq_ack, 4'h0);
    chk("b_isr_stall", stall, 0);
    IEN_d = 1'b1; step(); IEN_d = 1'b0;
    chk("b_isr_ien_ign", int_enabled, 0);
    chk("b_isr_stay", in_isr, 1);
    irq_i = 4'h0; RTI_d = 1'b1;
    step();                             // RETURN
    RTI_d = 1'b0;
    chk("b_rredir", pc_redirect, 1);
    chk("b_rtarget", pc_target, 16'h0123);
    chk("b_frest", flags_restore, 1);
    chk("b_flags_o", flags_o, 4'b1010);
    chk("b_rint_en", int_enabled, 1);
    chk("b_risr", in_isr, 0);
    step();                             // back in IDLE
    chk("b_idle_redir", pc_redirect, 0);
    chk("b_idle_frest", flags_restore, 0);
    chk("b_idle_stall", stall, 0);
    chk("b_idle_int_en", int_enabled, 1);
    step();
    chk("b_idle_quiet", stall, 0);

    // ---- priority: lines 1 and 3 together
    irq_i = 4'h0;
    do_reset();
    IEN_d = 1'b1; step(); IEN_d = 1'b0;
    irq_i = 4'b1010; pc_f = 16'h0200; flags_i = 4'b0101;
    step(); step(); step(); step();     // pend, DRAIN, DRAIN, VECTOR
    chk("p_t1", pc_target, 16'h0014);
    chk("p_ack1", irq_ack, 4'b0010);
    step();                             // ISR
    irq_i = 4'b1000; RTI_d = 1'b1;
    step(); RTI_d = 1'b0;               // RETURN
    chk("p_ret", pc_target, 16'h0200);
    chk("p_retflags", flags_o, 4'b0101);
    step(); step();                     // IDLE, DRAIN
    chk("p_flush2", flush, 1);
    step(); step();                     // DRAIN, VECTOR
    chk("p_redir3", pc_redirect, 1);
    chk("p_t3", pc_target, 16'h001C);
    chk("p_ack3", irq_ack, 4'b1000);

    // ---- pipe_ready held low in DRAIN, then reset during ISR
    irq_i = 4'h0;
    do_reset();
    IEN_d = 1'b1; step(); IEN_d = 1'b0;
    irq_i = 4'b0001; pipe_ready = 1'b0;
    step(); step();                     // pend, first DRAIN
    chk("d_flush", flush, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("d_stall", stall, 1);
      chk("d_noredir", pc_redirect, 0);
      chk("d_noflush", flush, 0);
    end
    pipe_ready = 1'b1;
    step();
    chk("d_redir", pc_redirect, 1);
    chk("d_target", pc_target, 16'h0010);
    chk("d_ack", irq_ack, 4'b0001);
    step();
    chk("d_isr", in_isr, 1);
    rst = 1'b1; step(); rst = 1'b0; irq_i = 4'h0;
    chk("r_isr", in_isr, 0);
    chk("r_int_en", int_enabled, 0);
    chk("r_redir", pc_redirect, 0);
    chk("r_stall", stall, 0);
    step();
    chk("r_idle_redir", pc_redirect, 0);

    // ---- IEN/IOF same cycle, IOF blocking entry
    IEN_d = 1'b1; IOF_d = 1'b1; step(); IEN_d = 1'b0; IOF_d = 1'b0;
    chk("both_off", int_enabled, 0);
    IEN_d = 1'b1; step(); IEN_d = 1'b0;
    chk("en_again", int_enabled, 1);
    irq_i = 4'b0010;
    step();                             // pending visible
    IOF_d = 1'b1; step(); IOF_d = 1'b0;
    chk("iof_block_stall", stall, 0);
    chk("iof_block_en", int_enabled, 0);
    step(); step();
    chk("iof_quiet_stall", stall, 0);
    chk("iof_quiet_redir", pc_redirect, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
